mul_seq: RTL and testbench

Parametrised sequential shift-add multiplier. Operands are WIDTH bits wide, and the block supports both unsigned and two's-complement signed modes. A start/busy/done handshake lets it sit as a multi-cycle arithmetic unit beside a controller. It is the generalised successor of the team's fixed 4-bit sequential multiplier: it adds width configurability, signed mode, status handshaking and back-to-back operation.

---
 rtl/mul_seq.sv | 117 +++++++++++
 tb/tb_mul_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed mode multiplies magnitudes and negates the result when signs differ.
module mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   din_m,
  input  logic [WIDTH-1:0]   din_q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] d_out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     dout_q, dout_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  mag_m, mag_q;

  // -2^(W-1) negates to itself, which read unsigned is the right magnitude
  always_comb begin
    mag_m = din_m;
    mag_q = din_q;
    if (signed_mode && din_m[WIDTH-1]) mag_m = -din_m;
    if (signed_mode && din_q[WIDTH-1]) mag_q = -din_q;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_m};
          mplier_d = mag_q;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = signed_mode
                   & (din_m[WIDTH-1] ^ din_q[WIDTH-1]);
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        dout_d  = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d_out = dout_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed checks of mul_seq at WIDTH=4 and WIDTH=8.
// Outputs are sampled on the falling edge.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0, s4 = 1'b0;
  logic [3:0] m4 = '0, q4 = '0;
  logic       busy4, done4;
  logic [7:0] d4;

  logic       start8 = 1'b0, s8 = 1'b0;
  logic [7:0] m8 = '0, q8 = '0;
  logic       busy8, done8;
  logic [15:0] d8;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  last4 = '0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .signed_mode(s4), .din_m(m4), .din_q(q4),
    .busy(busy4), .done(done4), .d_out(d4)
  );

  mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .signed_mode(s8), .din_m(m8), .din_q(q8),
    .busy(busy8), .done(done8), .d_out(d8)
  );

  task automatic run4(input logic sm, input logic [3:0] m,
                      input logic [3:0] q, input logic [7:0] exp,
                      input string nm);
    int c, bc;
    bit got, hold_ok;
    @(negedge clk);
    s4 = sm; m4 = m; q4 = q; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    c = 0; bc = 0; got = 0; hold_ok = 1;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (busy4) bc++;
      if (done4) got = 1;
      else if (d4 !== last4) hold_ok = 0;
    end
    n_tests++;
    if (c !== 6 || !got) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles done=%0b, need 6", nm, c, got);
    end
    n_tests++;
    if (bc !== 5) begin
      n_fail++;
      $display("FAIL %s busy_width: got %0d, need 5", nm, bc);
    end
    n_tests++;
    if (d4 !== exp) begin
      n_fail++;
      $display("FAIL %s d_out: got %h, need %h", nm, d4, exp);
    end
    n_tests++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL %s d_out_hold: changed during busy, need %h", nm, last4);
    end
    @(negedge clk);
    n_tests++;
    if (done4 !== 1'b0 || d4 !== exp) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b d_out=%h, need 0/%h", nm, done4, d4, exp);
    end
    last4 = exp;
  endtask

  task automatic run8(input logic sm, input logic [7:0] m,
                      input logic [7:0] q, input logic [15:0] exp,
                      input string nm);
    int c, bc;
    bit got;
    @(negedge clk);
    s8 = sm; m8 = m; q8 = q; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    c = 0; bc = 0; got = 0;
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      if (busy8) bc++;
      if (done8) got = 1;
    end
    n_tests++;
    if (c !== 10 || !got || bc !== 9) begin
      n_fail++;
      $display("FAIL %s timing: cycles=%0d busy=%0d done=%0b, need 10/9/1", nm, c, bc, got);
    end
    n_tests++;
    if (d8 !== exp) begin
      n_fail++;
      $display("FAIL %s d_out: got %h, need %h (m=%h q=%h s=%b)", nm, d8, exp, m, q, sm);
    end
    last8 = exp;
  endtask

  task automatic test_reset;
    n_tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset4: busy=%b done=%b d_out=%h, need 0/0/00", busy4, done4, d4);
    end
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || d8 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b d_out=%h, need 0/0/0000", busy8, done8, d8);
    end
  endtask

  task automatic test_unsigned4;
    run4(1'b0, 4'd1, 4'd3, 8'h03, "u_1x3");
    run4(1'b0, 4'd7, 4'd1, 8'h07, "u_7x1");
    run4(1'b0, 4'hA, 4'hF, 8'h96, "u_AxF");
    run4(1'b0, 4'h0, 4'hF, 8'h00, "u_0xF");
  endtask

  task automatic test_signed4;
    run4(1'b1, 4'hA, 4'hF, 8'h06, "s_m6xm1");
    run4(1'b1, 4'h8, 4'h8, 8'h40, "s_m8xm8");
    run4(1'b1, 4'h8, 4'h7, 8'hC8, "s_m8x7");
    run4(1'b1, 4'h3, 4'hE, 8'hFA, "s_3xm2");
    run4(1'b1, 4'h0, 4'h8, 8'h00, "s_0xm8");
  endtask

  task automatic test_back_to_back;
    logic [3:0] pm [3] = '{4'd3, 4'd2, 4'd9};
    logic [3:0] pq [3] = '{4'd5, 4'd7, 4'd9};
    logic [7:0] pe [3] = '{8'h0F, 8'h0E, 8'h51};
    int gap;
    bit got;
    @(negedge clk);
    s4 = 1'b0; m4 = pm[0]; q4 = pq[0]; start4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      gap = 0; got = 0;
      while (!got && gap < 20) begin
        @(negedge clk);
        gap++;
        if (done4) got = 1;
        else begin
          m4 = 4'hF; q4 = 4'hF;
        end
      end
      n_tests++;
      if (!got || gap !== 6 || d4 !== pe[k]) begin
        n_fail++;
        $display("FAIL b2b_%0d: gap=%0d done=%0b d_out=%h, need 6/1/%h", k, gap, got, d4, pe[k]);
      end
      if (k < 2) begin
        m4 = pm[k+1]; q4 = pq[k+1];
      end else start4 = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 8'h51) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b d_out=%h, need 0/0/51", busy4, done4, d4);
    end
    last4 = 8'h51;
  endtask

  task automatic test_reset_mid;
    bit quiet;
    @(negedge clk);
    s4 = 1'b0; m4 = 4'd5; q4 = 4'd5; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b d_out=%h, need 0/0/00", busy4, done4, d4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy4 || done4 || d4 !== 8'h00) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_abort: activity after reset, need idle with d_out 00 (got %h)", d4);
    end
    last4 = 8'h00;
    last8 = 16'h0;
    run4(1'b0, 4'd6, 4'd6, 8'h24, "post_reset");
  endtask

  task automatic test_width8;
    int a, b, p;
    logic sm;
    logic [7:0] m, q;
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u_255sq");
    run8(1'b1, 8'h80, 8'h80, 16'h4000, "w8_s_m128sq");
    run8(1'b1, 8'h7F, 8'hFF, 16'hFF81, "w8_s_127xm1");
    run8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8_s_m128x127");
    for (int i = 0; i < 1000; i++) begin
      sm = 1'($urandom_range(0, 1));
      m = 8'($urandom);
      q = 8'($urandom);
      a = sm ? int'($signed(m)) : int'(m);
      b = sm ? int'($signed(q)) : int'(q);
      p = a * b;
      run8(sm, m, q, 16'(p), "w8_rand");
    end
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_unsigned4;
    test_signed4;
    test_back_to_back;
    test_reset_mid;
    test_width8;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
